// File: rtl/maze_pkg.sv
// Shared maze definitions: ROM geometry, pipeline owner tags and cell codes
// used by the renderer, the game engine and the ROM arbiter.
package maze_pkg;

    localparam int ADDR_W = 4;   // one ROM word per maze row
    localparam int DATA_W = 32;  // 16 cells x 2 bits per row word
    localparam int WAIT_W = 4;   // starvation counter width (MAX_WAIT up to 15)

    // Which requester owns a pipeline slot.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DISP = 2'd1,
        OWN_GAME = 2'd2
    } owner_e;

    // 2-bit cell encoding inside a row word.
    typedef logic [1:0] cell_t;
    localparam cell_t CELL_PATH  = 2'b00;
    localparam cell_t CELL_WALL  = 2'b01;
    localparam cell_t CELL_ENTRY = 2'b10;
    localparam cell_t CELL_EXIT  = 2'b11;

    // Extract the cell at column col (0 = least significant pair) of a row word.
    function automatic cell_t cell_at(input logic [DATA_W-1:0] row, input logic [3:0] col);
        return row[{col, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/maze_rom_arbiter_if.sv
// Request/response bundle for the two maze-ROM requesters (display and game).
// master = requester side, slave = arbiter side.
interface maze_rom_arbiter_if;
    import maze_pkg::*;

    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_gnt;
    logic              disp_rvalid;
    logic [DATA_W-1:0] disp_rdata;
    logic              disp_stall;

    logic              game_req;
    logic [ADDR_W-1:0] game_addr;
    logic              game_gnt;
    logic              game_rvalid;
    logic [DATA_W-1:0] game_rdata;

    modport master (
        output disp_req, disp_addr, game_req, game_addr,
        input  disp_gnt, disp_rvalid, disp_rdata, disp_stall,
        input  game_gnt, game_rvalid, game_rdata
    );

    modport slave (
        input  disp_req, disp_addr, game_req, game_addr,
        output disp_gnt, disp_rvalid, disp_rdata, disp_stall,
        output game_gnt, game_rvalid, game_rdata
    );

endinterface

// File: rtl/arb_wait_ctr.sv
// Saturating starvation counter for the game port: counts consecutive cycles
// in which a game request was denied and raises force_game at the limit.
module arb_wait_ctr
    import maze_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic gnt,
    output logic force_game
);

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] cnt;

    // Clear on grant or withdrawal, otherwise count denied cycles up to the limit.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples
        // the pre-edge values regardless of block ordering.
        if (rst) begin
            cnt <= '0;
        end else if (gnt || !req) begin
            cnt <= '0;
        end else if (cnt != LIMIT) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign force_game = (cnt == LIMIT);

endmodule

// File: rtl/maze_rom_arbiter.sv
// Shares the combinational maze ROM between the display (priority) and game
// (starvation-guarded) requesters. Registered address, registered data and a
// two-stage owner tag give a fixed 2-cycle grant-to-rvalid latency.
module maze_rom_arbiter
    import maze_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    maze_rom_arbiter_if.slave bus,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

    logic   force_game;
    logic   force_take;
    owner_e tag1;
    owner_e tag2;

    arb_wait_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_ctr (
        .clk        (clk),
        .rst        (rst),
        .req        (bus.game_req),
        .gnt        (bus.game_gnt),
        .force_game (force_game)
    );

    // Grant decision: forced game win at the wait limit, else display first, else game.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can
        // leave it unassigned and infer a latch.
        force_take    = 1'b0;
        bus.disp_gnt   = 1'b0;
        bus.game_gnt   = 1'b0;
        bus.disp_stall = 1'b0;

        force_take     = force_game & bus.game_req;
        bus.disp_gnt   = ~rst & bus.disp_req & ~force_take;
        // Game grant follows the rule alone; the pipeline reset discards it.
        bus.game_gnt   = bus.game_req & (force_game | ~bus.disp_req);
        bus.disp_stall = ~rst & bus.disp_req & ~bus.disp_gnt;
    end

    // Address/tag stage, data/tag stage and response registers.
    always_ff @(posedge clk) begin
        // NOTE: only control and datapath registers exist here, all with explicit
        // reset values; the ROM itself lives outside this block.
        if (rst) begin
            rom_addr       <= '0;
            tag1           <= OWN_NONE;
            tag2           <= OWN_NONE;
            bus.disp_rdata <= '0;
            bus.game_rdata <= '0;
        end else begin
            if (bus.disp_gnt) begin
                rom_addr <= bus.disp_addr;
                tag1     <= OWN_DISP;
            end else if (bus.game_gnt) begin
                rom_addr <= bus.game_addr;
                tag1     <= OWN_GAME;
            end else begin
                tag1     <= OWN_NONE;
            end

            tag2 <= tag1;
            if (tag1 == OWN_DISP) bus.disp_rdata <= rom_data;
            if (tag1 == OWN_GAME) bus.game_rdata <= rom_data;
        end
    end

    // The second-stage tag is the registered one-cycle valid pulse.
    assign bus.disp_rvalid = (tag2 == OWN_DISP);
    assign bus.game_rvalid = (tag2 == OWN_GAME);

endmodule

// File: tb/tb_maze_rom_arbiter.sv
// Directed bench for maze_rom_arbiter: stimulus pushes expected responses into
// a scoreboard queue; a negedge monitor pops and compares on every rvalid.
module tb_maze_rom_arbiter;
    import maze_pkg::*;

    typedef struct {
        logic        is_game;
        logic [31:0] data;
        int          due;
    } resp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;

    maze_rom_arbiter_if bus ();

    maze_rom_arbiter #(
        .MAX_WAIT (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .rom_addr (rom_addr),
        .rom_data (rom_data)
    );

    always #5 clk = ~clk;

    // Hand-written maze layout.
    function automatic logic [31:0] rom_word(input logic [3:0] a);
        case (a)
            4'h0: return 32'h5555_5556;
            4'h1: return 32'h4000_0001;
            4'h2: return 32'h4154_1501;
            4'h3: return 32'h4104_0441;
            4'h4: return 32'h4515_5101;
            4'h5: return 32'h5001_5155;
            4'h6: return 32'h4441_0011;
            4'h7: return 32'h4504_4541;
            4'h8: return 32'h4010_4401;
            4'h9: return 32'h4545_1045;
            4'hA: return 32'h4001_0101;
            4'hB: return 32'h5144_5415;
            4'hC: return 32'h4104_0101;
            4'hD: return 32'h4551_5545;
            4'hE: return 32'h4000_0001;
            default: return 32'h9555_5555;
        endcase
    endfunction

    assign rom_data = rom_word(rom_addr);

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [3:0]  exp_rom = 4'h0;
    resp_t       sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every rvalid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.disp_rvalid === 1'b1 || bus.game_rvalid === 1'b1) begin
            if (bus.disp_rvalid === 1'b1 && bus.game_rvalid === 1'b1) begin
                check("dual_rvalid", 32'd1, 32'd0);
            end else if (sb.size() == 0) begin
                check("unexpected_rvalid", {31'd0, bus.game_rvalid}, {31'd0, 1'b0});
            end else begin
                resp_t r;
                r = sb.pop_front();
                check("resp_port", {31'd0, bus.game_rvalid}, {31'd0, r.is_game});
                check("resp_cycle", cyc, r.due);
                check("resp_data", r.is_game ? bus.game_rdata : bus.disp_rdata, r.data);
            end
        end
    end

    // One clock of stimulus with the expected grants for that cycle.
    task automatic step(input logic r, input logic dq, input logic [3:0] da,
                        input logic gq, input logic [3:0] ga,
                        input logic ed, input logic eg, input logic push, input string tag);
        rst           = r;
        bus.disp_req  = dq;
        bus.disp_addr = da;
        bus.game_req  = gq;
        bus.game_addr = ga;
        @(negedge clk);
        check({tag, " rom_addr"}, {28'd0, rom_addr}, {28'd0, exp_rom});
        check({tag, " disp_gnt"}, {31'd0, bus.disp_gnt}, {31'd0, ed});
        if (!r) check({tag, " game_gnt"}, {31'd0, bus.game_gnt}, {31'd0, eg});
        check({tag, " disp_stall"}, {31'd0, bus.disp_stall}, {31'd0, ~r & dq & ~ed});
        if (push && ed) sb.push_back('{1'b0, rom_word(da), cyc + 2});
        if (push && eg) sb.push_back('{1'b1, rom_word(ga), cyc + 2});
        @(posedge clk);
        #1;
        if (r)       exp_rom = 4'h0;
        else if (ed) exp_rom = da;
        else if (eg) exp_rom = ga;
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, tag);
    endtask

    initial begin
        // Reset, then idle.
        step(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, "reset");
        step(1'b1, 1'b1, 4'h2, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, "reset_dreq");
        idle(5, "idle");

        // Single game read.
        step(1'b0, 1'b0, 4'h0, 1'b1, 4'h5, 1'b0, 1'b1, 1'b1, "game_rd");
        idle(3, "game_rd_tail");
        check("game_rdata_hold", bus.game_rdata, 32'h5001_5155);

        // Both held: 4 display grants, then a forced game grant, twice.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++)
                step(1'b0, 1'b1, 4'h2, 1'b1, 4'h9, 1'b1, 1'b0, 1'b1, "contend_disp");
            step(1'b0, 1'b1, 4'h2, 1'b1, 4'h9, 1'b0, 1'b1, 1'b1, "contend_game");
        end
        idle(3, "contend_tail");

        // Alternating grants, responses in order.
        step(1'b0, 1'b1, 4'h3, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, "alt_d3");
        step(1'b0, 1'b0, 4'h0, 1'b1, 4'hB, 1'b0, 1'b1, 1'b1, "alt_gB");
        step(1'b0, 1'b1, 4'h7, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, "alt_d7");
        idle(3, "alt_tail");

        // Reset one cycle after a display grant: that response must never appear.
        step(1'b0, 1'b1, 4'h4, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, "rst_grant");
        step(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, "rst_mid");
        check("rst disp_rdata", bus.disp_rdata, 32'h0);
        check("rst game_rdata", bus.game_rdata, 32'h0);
        check("rst disp_rvalid", {31'd0, bus.disp_rvalid}, 32'd0);
        check("rst game_rvalid", {31'd0, bus.game_rvalid}, 32'd0);
        idle(4, "rst_tail");

        // Withdrawal at wait_cnt=2 clears the counter.
        step(1'b0, 1'b1, 4'h1, 1'b1, 4'hC, 1'b1, 1'b0, 1'b1, "wd_d0");
        step(1'b0, 1'b1, 4'h1, 1'b1, 4'hC, 1'b1, 1'b0, 1'b1, "wd_d1");
        step(1'b0, 1'b1, 4'h1, 1'b0, 4'hC, 1'b1, 1'b0, 1'b1, "wd_drop");
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, 4'h1, 1'b1, 4'hC, 1'b1, 1'b0, 1'b1, "wd_deny");
        step(1'b0, 1'b1, 4'h1, 1'b1, 4'hC, 1'b0, 1'b1, 1'b1, "wd_force");
        idle(3, "wd_tail");

        // Same address from both ports: two serialised accesses.
        step(1'b0, 1'b1, 4'h6, 1'b1, 4'h6, 1'b1, 1'b0, 1'b1, "same_d");
        step(1'b0, 1'b0, 4'h6, 1'b1, 4'h6, 1'b0, 1'b1, 1'b1, "same_g");
        idle(4, "same_tail");

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/maze_rom_arbiter.md
Name: maze_rom_arbiter

Overview:
- Shares the single maze-layout ROM (4-bit address in, 32-bit row word out, purely combinational) between two requesters.
- Requester 1 is the pixel renderer (display port, deadline-critical). Requester 2 is the player/game-logic engine (game port, wall lookups).
- Fixed priority to the display port, with a starvation guard for the game port.
- Registered ROM address, registered read data, tagged return path; sits between both requesters and the ROM in the maze display top level.

Parameters:
ADDR_W, 4, ROM address width
DATA_W, 32, ROM word width (16 cells x 2 bits per row word)
MAX_WAIT, 4, consecutive denied game-request cycles before the game port is forced to win (legal range 1..15)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
disp_req  in  1  display read request; held with disp_addr stable until granted
disp_addr  in  ADDR_W  display read address
disp_gnt  out  1  display request accepted this cycle (combinational)
disp_rvalid  out  1  one-cycle pulse: disp_rdata valid
disp_rdata  out  DATA_W  display read data
disp_stall  out  1  one-cycle pulse: disp_req was present but denied
game_req  in  1  game read request; held with game_addr stable until granted
game_addr  in  ADDR_W  game read address
game_gnt  out  1  game request accepted this cycle (combinational)
game_rvalid  out  1  one-cycle pulse: game_rdata valid
game_rdata  out  DATA_W  game read data
rom_addr  out  ADDR_W  registered address to ROM
rom_data  in  DATA_W  ROM word for rom_addr (combinational ROM)

Behaviour:
- Reset (rst=1 at posedge): rom_addr=0, disp_rdata=0, game_rdata=0, disp_rvalid=0, game_rvalid=0, wait counter=0, both pipeline owner tags=NONE.
- disp_gnt and disp_stall are combinational and are 0 while rst=1. game_gnt is also combinational; it is not forced low during reset, but the reset branch of the pipeline overrides it, so no rvalid ever follows a reset-cycle grant.
- Grant rule, evaluated every cycle. At most one grant per cycle; back-to-back grants allowed.
  - wait_cnt==MAX_WAIT and game_req -> game_gnt=1, disp_gnt=0.
  - else disp_req -> disp_gnt=1.
  - else game_req -> game_gnt=1.
- disp_stall=disp_req & ~disp_gnt.
- Wait counter (4-bit):
  - clears when game_gnt or ~game_req.
  - increments when game_req & ~game_gnt.
  - saturates at MAX_WAIT.
- Pipeline: grant in cycle N.
  - Edge ending N: rom_addr<=granted addr; tag1<=owner.
  - Edge ending N+1: data of tag1's port <=rom_data; tag2<=tag1.
  - Cycle N+2: rvalid of tag2's port is high for exactly one cycle.
  - Fixed read latency of 2 cycles from grant.
- No grant in a cycle -> tag1<=NONE; rom_addr holds its value.
- rdata registers hold their last value when not updated.
- Order: responses return in grant order; the pipeline never stalls (no backpressure on the return path).
- Requests whose req drops before grant are silently withdrawn; no response is generated.
- Reset mid-operation: in-flight tags are cleared, so no rvalid is issued for pre-reset grants.
- Same address requested by both ports: still two separate accesses, serialised by the grant rule.

Decomposition:
- Shared package maze_pkg:
  - ADDR_W, DATA_W constants.
  - owner_e enum {OWN_NONE, OWN_DISP, OWN_GAME}.
  - cell-code constants (2-bit path/wall/entry/exit), reused by renderer and game engine.
- One sub-module, arb_wait_ctr: saturating starvation counter with clear/inc/limit compare. It outputs the force_game flag.

Test Plan:
- Reset, then idle for 5 cycles -> all rvalid=0, rom_addr=0, no gnt, no stall.
- Single game read, addr 4'h5 with rom[5]=32'h5001_5155 -> game_gnt in cycle N; game_rvalid in N+2 with game_rdata=32'h5001_5155; disp_rvalid stays 0.
- disp_req and game_req held continuously, MAX_WAIT=4 -> 4 display grants, then 1 game grant, then the pattern repeats. disp_stall pulses exactly on each game-grant cycle.
- Alternating grants disp@3, game@0xB, disp@7 on consecutive cycles -> rvalids return in the same order 2 cycles later, each with the correct ROM word; rom_addr sequence is 3, B, 7.
- rst asserted one cycle after a display grant -> no disp_rvalid afterwards; all outputs return to their reset values on the next edge.
- Game request withdrawn at wait_cnt=2 (game_req=0 for 1 cycle), then reasserted -> counter clears to 0; forced game grant occurs only after 4 further denied cycles.
